mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all ports.
REQ-002 Parameter DATA_W, default 32, data width of all ports; byte-enable width is DATA_W/8.
REQ-003 Parameter MAX_OUT, default 2, maximum outstanding granted transactions awaiting rvalid; legal range 1..4.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk_i  in  1  clock; all state updates on the rising edge.
REQ-006 rst_i  in  1  asynchronous active-high reset.
REQ-007 m_req_i  in  2  per-master request; bit 0 = instruction port, bit 1 = data port.
REQ-008 m_addr_i  in  2xADDR_W  per-master address.
REQ-009 m_we_i  in  2  per-master write enable.
REQ-010 m_be_i  in  2xDATA_W/8  per-master byte enables.
REQ-011 m_wdata_i  in  2xDATA_W  per-master write data.
REQ-012 m_gnt_o  out  2  per-master grant.
REQ-013 m_rvalid_o  out  2  per-master response valid.
REQ-014 m_rdata_o  out  2xDATA_W  per-master read data; both equal s_rdata_i.
REQ-015 s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o  out  1/ADDR_W/1/DATA_W/8/DATA_W  shared memory request port.
REQ-016 s_gnt_i, s_rvalid_i  in  1/1  memory grant and response valid; s_rdata_i  in  DATA_W  memory read data.
REQ-017 err_o  out  1  sticky protocol error flag.

Function
REQ-018 s_req_o SHALL be 1 when the selected master's request is 1 and the outstanding count is below MAX_OUT, or is exactly MAX_OUT with s_rvalid_i=1 in the same cycle.
REQ-019 s_addr_o, s_we_o, s_be_o and s_wdata_o SHALL be the selected master's fields, driven combinationally.
REQ-020 m_gnt_o[k] SHALL equal s_gnt_i AND s_req_o AND (selected==k); at most one bit of m_gnt_o is ever 1.
REQ-021 FSM ARB: when exactly one master requests, select it; when both request, select the master pointed to by the round-robin pointer rr.
REQ-022 rr SHALL toggle to the other master on every completed grant and hold otherwise.
REQ-023 ARB goes to HOLD when s_req_o=1 and s_gnt_i=0.
REQ-024 In HOLD the selection is frozen on the latched master until s_gnt_i=1, then the FSM returns to ARB.
REQ-025 If the latched master drops its request in HOLD, the FSM returns to ARB without a grant and err_o is set.
REQ-026 Every grant SHALL push the granted master ID into an ID FIFO of depth MAX_OUT.
REQ-027 Every s_rvalid_i SHALL pop the ID FIFO and assert m_rvalid_o[ID] for that cycle only, combinationally.
REQ-028 A push and a pop in the same cycle SHALL leave the count unchanged; this is legal when the FIFO is full.
REQ-029 s_rvalid_i with an empty FIFO SHALL assert no m_rvalid_o and SHALL set err_o.
REQ-030 The read/write pointers SHALL wrap modulo MAX_OUT.
REQ-031 err_o SHALL clear only on reset.
REQ-032 Latency added by the block SHALL be zero cycles on both the request and response paths.

Reset
REQ-033 Reset SHALL set state to ARB, rr=0 (instruction master favoured), FIFO count and pointers to 0, and err_o=0.
REQ-034 During reset m_gnt_o, m_rvalid_o and s_req_o SHALL be 0.
REQ-035 Reset asserted mid-transaction SHALL discard all outstanding IDs; responses arriving after reset release are treated per REQ-029.

Structure
REQ-036 Package mem_arbiter_pkg SHALL hold the master ID type (1 bit), the named constants MST_INSTR=0 and MST_DATA=1, and the FSM state enum {ARB, HOLD}.
REQ-037 The ID FIFO SHALL be a sub-module, id_fifo, parameterised by depth and width, with push, pop, full, empty and count.
REQ-038 Arbitration, the FSM and muxing SHALL live in mem_arbiter.

Verification
REQ-039 Single read: m_req_i=01, addr 0x100, s_gnt_i=1 -> m_gnt_o=01 the same cycle; the next-cycle s_rvalid_i with rdata 0xCAFE0001 -> m_rvalid_o=01 and m_rdata_o[0]=0xCAFE0001.
REQ-040 Contention: m_req_i=11 held 4 cycles, s_gnt_i=1, rvalid one cycle after each grant -> grants alternate 01, 10, 01, 10 and rvalids follow the same order.
REQ-041 Backpressure: m_req_i=11, s_gnt_i=0 for 3 cycles then 1 -> s_addr_o stable on the master selected in cycle 0 for all 4 cycles, and a single grant goes to that master.
REQ-042 Full FIFO: MAX_OUT=2, two grants with no rvalid -> s_req_o=0 in the third cycle; s_rvalid_i=1 in the fourth cycle -> a grant is allowed the same cycle and count stays at 2.
REQ-043 Error: s_rvalid_i=1 after reset with no request -> m_rvalid_o=00 and err_o=1 until the next reset.
REQ-044 Reset mid-flight: assert rst_i with count=1 -> count=0, m_gnt_o=00 and rr=0 after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master memory arbiter.
//   mst_id_t     : master identifier (1 bit)
//   MST_INSTR    : instruction port ID (0)
//   MST_DATA     : data port ID (1)
//   arb_state_t  : arbitration FSM states {ARB, HOLD}
package mem_arbiter_pkg;

  typedef logic mst_id_t;

  localparam mst_id_t MST_INSTR = 1'b0;
  localparam mst_id_t MST_DATA  = 1'b1;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of every bus signal around the memory arbiter.
//   m_*  : two requesting masters (index 0 = instruction, 1 = data)
//   s_*  : shared memory port
//   err_o: sticky protocol error
// Modports:
//   slave  : the arbiter's view (accepts master requests, drives memory port)
//   master : the environment's view (masters plus memory)
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [1:0]             m_req_i;
  logic [1:0][ADDR_W-1:0] m_addr_i;
  logic [1:0]             m_we_i;
  logic [1:0][BE_W-1:0]   m_be_i;
  logic [1:0][DATA_W-1:0] m_wdata_i;
  logic [1:0]             m_gnt_o;
  logic [1:0]             m_rvalid_o;
  logic [1:0][DATA_W-1:0] m_rdata_o;

  logic                   s_req_o;
  logic [ADDR_W-1:0]      s_addr_o;
  logic                   s_we_o;
  logic [BE_W-1:0]        s_be_o;
  logic [DATA_W-1:0]      s_wdata_o;
  logic                   s_gnt_i;
  logic                   s_rvalid_i;
  logic [DATA_W-1:0]      s_rdata_i;

  logic                   err_o;

  modport slave (
    input  m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
    input  s_gnt_i, s_rvalid_i, s_rdata_i,
    output m_gnt_o, m_rvalid_o, m_rdata_o,
    output s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
    output err_o
  );

  modport master (
    output m_req_i, m_addr_i, m_we_i, m_be_i, m_wdata_i,
    output s_gnt_i, s_rvalid_i, s_rdata_i,
    input  m_gnt_o, m_rvalid_o, m_rdata_o,
    input  s_req_o, s_addr_o, s_we_o, s_be_o, s_wdata_o,
    input  err_o
  );

endinterface

// File: rtl/id_fifo.sv
// Small FIFO recording which master owns each outstanding transaction.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i       : write data_i (accepted when not full, or full with pop_i)
//   pop_i        : discard head entry (ignored when empty)
//   data_i       : entry to write
//   data_o       : head entry (undefined content when empty)
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
//   count_o      : number of stored entries
module id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             wptr_q;
  ptr_t             rptr_q;
  cnt_t             count_q;
  logic             wr_en;
  logic             rd_en;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic ptr_t bump(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign full_o  = (count_q == cnt_t'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem[rptr_q];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign wr_en = push_i && (!full_o || pop_i);
  assign rd_en = pop_i && !empty_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem[wptr_q] <= data_i;
        wptr_q      <= bump(wptr_q);
      end
      if (rd_en) begin
        rptr_q <= bump(rptr_q);
      end
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + cnt_t'(1);
        2'b01:   count_q <= count_q - cnt_t'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter onto a single pipelined memory port.
// Zero added latency: requests and responses pass through combinationally;
// an ID FIFO routes each response back to the master that was granted.
// Ports:
//   clk_i : clock (rising edge)
//   rst_i : asynchronous active-high reset
//   bus   : mem_arbiter_if.slave -- master request/grant/response lanes,
//           shared memory request port and sticky err_o
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  arb_state_t        state_q, state_d;
  mst_id_t           rr_q, rr_d;
  mst_id_t           held_q, held_d;
  logic              err_q, err_d;
  mst_id_t           sel;

  logic              sel_req;
  logic              can_issue;
  logic              s_req;
  logic              grant;
  logic              pop;
  logic              orphan;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  mst_id_t           head_id;

  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;

  // Master selection: frozen in HOLD, otherwise the sole requester, or rr
  // when both (or neither) request.
  always_comb begin
    sel = rr_q;
    if (state_q == HOLD) begin
      sel = held_q;
    end else if (bus.m_req_i == 2'b01) begin
      sel = MST_INSTR;
    end else if (bus.m_req_i == 2'b10) begin
      sel = MST_DATA;
    end
  end

  assign sel_req   = bus.m_req_i[sel];
  // A full FIFO may still accept a new ID when a response retires one now.
  assign can_issue = !fifo_full || bus.s_rvalid_i;
  assign s_req     = sel_req && can_issue && !rst_i;
  assign grant     = s_req && bus.s_gnt_i;
  assign pop       = bus.s_rvalid_i && !fifo_empty && !rst_i;
  assign orphan    = bus.s_rvalid_i && fifo_empty;

  assign sel_addr  = bus.m_addr_i[sel];
  assign sel_be    = bus.m_be_i[sel];
  assign sel_wdata = bus.m_wdata_i[sel];

  assign bus.s_req_o   = s_req;
  assign bus.s_addr_o  = sel_addr;
  assign bus.s_we_o    = bus.m_we_i[sel];
  assign bus.s_be_o    = sel_be;
  assign bus.s_wdata_o = sel_wdata;
  assign bus.err_o     = err_q;

  always_comb begin
    bus.m_gnt_o      = '0;
    bus.m_gnt_o[sel] = grant;
  end

  always_comb begin
    bus.m_rvalid_o          = '0;
    bus.m_rvalid_o[head_id] = pop;
  end

  always_comb begin
    bus.m_rdata_o[0] = bus.s_rdata_i;
    bus.m_rdata_o[1] = bus.s_rdata_i;
  end

  id_fifo #(
    .DEPTH (MAX_OUT),
    .WIDTH (1)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (grant),
    .pop_i   (pop),
    .data_i  (sel),
    .data_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    held_d  = held_q;
    rr_d    = rr_q;
    err_d   = err_q;

    if (grant) begin
      rr_d = ~rr_q;
    end
    if (orphan) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      ARB: begin
        if (s_req && !bus.s_gnt_i) begin
          state_d = HOLD;
          held_d  = sel;
        end
      end
      HOLD: begin
        if (!bus.m_req_i[held_q]) begin
          state_d = ARB;
          err_d   = 1'b1;
        end else if (grant) begin
          state_d = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB;
      rr_q    <= MST_INSTR;
      held_q  <= MST_INSTR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      held_q  <= held_d;
      err_q   <= err_d;
    end
  end

  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    32'(fifo_count) <= MAX_OUT);

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(bus.m_gnt_o));

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .MAX_OUT (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  localparam logic [31:0] A_INSTR = 32'h0000_0100;
  localparam logic [31:0] A_DATA  = 32'h0000_2000;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Drive one cycle's inputs at the falling edge; sample 1 ns later.
  task automatic cyc(input logic [1:0] req, input logic gnt, input logic rv,
                     input logic [31:0] rd);
    @(negedge clk);
    bus.m_req_i    = req;
    bus.s_gnt_i    = gnt;
    bus.s_rvalid_i = rv;
    bus.s_rdata_i  = rd;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst            = 1'b1;
    bus.m_req_i    = 2'b00;
    bus.s_gnt_i    = 1'b0;
    bus.s_rvalid_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    bus.m_req_i    = 2'b11;
    bus.s_gnt_i    = 1'b1;
    bus.s_rvalid_i = 1'b1;
    #1;
    checks++;
    if (bus.s_req_o !== 1'b0) begin
      failures++; $display("FAIL rst_sreq got=%b exp=0", bus.s_req_o);
    end
    checks++;
    if (bus.m_gnt_o !== 2'b00) begin
      failures++; $display("FAIL rst_gnt got=%b exp=00", bus.m_gnt_o);
    end
    checks++;
    if (bus.m_rvalid_o !== 2'b00) begin
      failures++; $display("FAIL rst_rvalid got=%b exp=00", bus.m_rvalid_o);
    end
    @(negedge clk);
    bus.m_req_i    = 2'b00;
    bus.s_gnt_i    = 1'b0;
    bus.s_rvalid_i = 1'b0;
    rst            = 1'b0;
    #1;
    checks++;
    if (bus.err_o !== 1'b0 || dut.rr_q !== MST_INSTR || dut.fifo_count !== 2'd0
        || dut.state_q !== ARB) begin
      failures++;
      $display("FAIL rst_state got err=%b rr=%b cnt=%0d st=%0d exp err=0 rr=0 cnt=0 st=ARB",
               bus.err_o, dut.rr_q, dut.fifo_count, dut.state_q);
    end
  endtask

  task automatic test_single_read();
    apply_reset();
    cyc(2'b01, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus.m_gnt_o !== 2'b01 || bus.s_req_o !== 1'b1 || bus.s_addr_o !== A_INSTR) begin
      failures++;
      $display("FAIL single_req got gnt=%b sreq=%b addr=%h exp gnt=01 sreq=1 addr=%h",
               bus.m_gnt_o, bus.s_req_o, bus.s_addr_o, A_INSTR);
    end
    cyc(2'b00, 1'b0, 1'b1, 32'hCAFE_0001);
    checks++;
    if (bus.m_rvalid_o !== 2'b01 || bus.m_rdata_o[0] !== 32'hCAFE_0001) begin
      failures++;
      $display("FAIL single_resp got rv=%b rdata=%h exp rv=01 rdata=cafe0001",
               bus.m_rvalid_o, bus.m_rdata_o[0]);
    end
    cyc(2'b00, 1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.m_rvalid_o !== 2'b00 || dut.fifo_count !== 2'd0 || bus.err_o !== 1'b0) begin
      failures++;
      $display("FAIL single_after got rv=%b cnt=%0d err=%b exp rv=00 cnt=0 err=0",
               bus.m_rvalid_o, dut.fifo_count, bus.err_o);
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp_gnt [5];
    logic [1:0] exp_rv  [5];
    exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00};
    exp_rv  = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      cyc((i < 4) ? 2'b11 : 2'b00, i < 4, i >= 1, 32'hD000_0000 + 32'(i));
      checks++;
      if (bus.m_gnt_o !== exp_gnt[i]) begin
        failures++;
        $display("FAIL cont_gnt[%0d] got=%b exp=%b", i, bus.m_gnt_o, exp_gnt[i]);
      end
      checks++;
      if (bus.m_rvalid_o !== exp_rv[i]) begin
        failures++;
        $display("FAIL cont_rv[%0d] got=%b exp=%b", i, bus.m_rvalid_o, exp_rv[i]);
      end
      if (i == 1 || i == 3) begin
        checks++;
        if (bus.s_addr_o !== A_DATA || bus.s_we_o !== 1'b1 || bus.s_be_o !== 4'h3
            || bus.s_wdata_o !== 32'h5555_AAAA) begin
          failures++;
          $display("FAIL cont_dfields[%0d] got addr=%h we=%b be=%h wd=%h exp %h 1 3 5555aaaa",
                   i, bus.s_addr_o, bus.s_we_o, bus.s_be_o, bus.s_wdata_o, A_DATA);
        end
      end
      if (i >= 1) begin
        checks++;
        if (bus.m_rdata_o[1] !== 32'hD000_0000 + 32'(i)) begin
          failures++;
          $display("FAIL cont_rdata[%0d] got=%h exp=%h", i, bus.m_rdata_o[1],
                   32'hD000_0000 + 32'(i));
        end
      end
    end
    cyc(2'b00, 1'b0, 1'b0, 32'h0);
    checks++;
    if (dut.fifo_count !== 2'd0 || bus.err_o !== 1'b0) begin
      failures++;
      $display("FAIL cont_end got cnt=%0d err=%b exp cnt=0 err=0", dut.fifo_count, bus.err_o);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] req_v [7];
    logic       gnt_v [7];
    logic [1:0] exp_gnt [7];
    req_v   = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b11, 2'b11};
    gnt_v   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_gnt = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(req_v[i], gnt_v[i], 1'b0, 32'h0);
      checks++;
      if (bus.s_addr_o !== A_INSTR || bus.s_req_o !== 1'b1) begin
        failures++;
        $display("FAIL bp_addr[%0d] got addr=%h sreq=%b exp addr=%h sreq=1",
                 i, bus.s_addr_o, bus.s_req_o, A_INSTR);
      end
      checks++;
      if (bus.m_gnt_o !== exp_gnt[i]) begin
        failures++;
        $display("FAIL bp_gnt[%0d] got=%b exp=%b", i, bus.m_gnt_o, exp_gnt[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      cyc(2'b00, 1'b0, 1'b1, 32'h0);
      checks++;
      if (bus.m_rvalid_o !== 2'b01) begin
        failures++;
        $display("FAIL bp_drain[%0d] got=%b exp=01", i, bus.m_rvalid_o);
      end
    end
  endtask

  task automatic test_full_fifo();
    apply_reset();
    cyc(2'b01, 1'b1, 1'b0, 32'h0);
    cyc(2'b10, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus.m_gnt_o !== 2'b10) begin
      failures++; $display("FAIL full_gnt2 got=%b exp=10", bus.m_gnt_o);
    end
    cyc(2'b11, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus.s_req_o !== 1'b0 || bus.m_gnt_o !== 2'b00 || dut.fifo_count !== 2'd2) begin
      failures++;
      $display("FAIL full_block got sreq=%b gnt=%b cnt=%0d exp sreq=0 gnt=00 cnt=2",
               bus.s_req_o, bus.m_gnt_o, dut.fifo_count);
    end
    cyc(2'b11, 1'b1, 1'b1, 32'h0);
    checks++;
    if (bus.s_req_o !== 1'b1 || bus.m_gnt_o !== 2'b01 || bus.m_rvalid_o !== 2'b01) begin
      failures++;
      $display("FAIL full_swap got sreq=%b gnt=%b rv=%b exp sreq=1 gnt=01 rv=01",
               bus.s_req_o, bus.m_gnt_o, bus.m_rvalid_o);
    end
    cyc(2'b00, 1'b0, 1'b1, 32'h0);
    checks++;
    if (dut.fifo_count !== 2'd2 || bus.m_rvalid_o !== 2'b10) begin
      failures++;
      $display("FAIL full_cnt got cnt=%0d rv=%b exp cnt=2 rv=10", dut.fifo_count, bus.m_rvalid_o);
    end
    cyc(2'b00, 1'b0, 1'b1, 32'h0);
    checks++;
    if (bus.m_rvalid_o !== 2'b01) begin
      failures++; $display("FAIL full_drain got=%b exp=01", bus.m_rvalid_o);
    end
    cyc(2'b00, 1'b0, 1'b0, 32'h0);
    checks++;
    if (dut.fifo_count !== 2'd0 || bus.err_o !== 1'b0) begin
      failures++;
      $display("FAIL full_end got cnt=%0d err=%b exp cnt=0 err=0", dut.fifo_count, bus.err_o);
    end
  endtask

  task automatic test_hold_drop();
    apply_reset();
    cyc(2'b10, 1'b0, 1'b0, 32'h0);
    cyc(2'b00, 1'b1, 1'b0, 32'h0);
    checks++;
    if (bus.m_gnt_o !== 2'b00 || bus.err_o !== 1'b0) begin
      failures++;
      $display("FAIL drop_cycle got gnt=%b err=%b exp gnt=00 err=0", bus.m_gnt_o, bus.err_o);
    end
    cyc(2'b00, 1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.err_o !== 1'b1 || dut.state_q !== ARB || dut.fifo_count !== 2'd0) begin
      failures++;
      $display("FAIL drop_err got err=%b st=%0d cnt=%0d exp err=1 st=ARB cnt=0",
               bus.err_o, dut.state_q, dut.fifo_count);
    end
  endtask

  task automatic test_orphan_rvalid();
    apply_reset();
    cyc(2'b00, 1'b0, 1'b1, 32'h1234_5678);
    checks++;
    if (bus.m_rvalid_o !== 2'b00 || bus.err_o !== 1'b0) begin
      failures++;
      $display("FAIL orphan_rv got rv=%b err=%b exp rv=00 err=0", bus.m_rvalid_o, bus.err_o);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(2'b00, 1'b0, 1'b0, 32'h0);
      checks++;
      if (bus.err_o !== 1'b1) begin
        failures++; $display("FAIL orphan_sticky[%0d] got=%b exp=1", i, bus.err_o);
      end
    end
    apply_reset();
    #1;
    checks++;
    if (bus.err_o !== 1'b0) begin
      failures++; $display("FAIL orphan_clear got=%b exp=0", bus.err_o);
    end
  endtask

  task automatic test_reset_midflight();
    apply_reset();
    cyc(2'b01, 1'b1, 1'b0, 32'h0);
    cyc(2'b11, 1'b1, 1'b0, 32'h0);
    rst = 1'b1;
    #1;
    checks++;
    if (bus.m_gnt_o !== 2'b00 || bus.s_req_o !== 1'b0 || dut.fifo_count !== 2'd0) begin
      failures++;
      $display("FAIL mid_inrst got gnt=%b sreq=%b cnt=%0d exp gnt=00 sreq=0 cnt=0",
               bus.m_gnt_o, bus.s_req_o, dut.fifo_count);
    end
    @(negedge clk);
    rst            = 1'b0;
    bus.m_req_i    = 2'b00;
    bus.s_gnt_i    = 1'b0;
    #1;
    checks++;
    if (dut.fifo_count !== 2'd0 || bus.m_gnt_o !== 2'b00 || dut.rr_q !== MST_INSTR) begin
      failures++;
      $display("FAIL mid_release got cnt=%0d gnt=%b rr=%b exp cnt=0 gnt=00 rr=0",
               dut.fifo_count, bus.m_gnt_o, dut.rr_q);
    end
    cyc(2'b00, 1'b0, 1'b1, 32'h0);
    checks++;
    if (bus.m_rvalid_o !== 2'b00) begin
      failures++; $display("FAIL mid_stale_rv got=%b exp=00", bus.m_rvalid_o);
    end
    cyc(2'b00, 1'b0, 1'b0, 32'h0);
    checks++;
    if (bus.err_o !== 1'b1) begin
      failures++; $display("FAIL mid_stale_err got=%b exp=1", bus.err_o);
    end
  endtask

  initial begin
    bus.m_req_i      = 2'b00;
    bus.m_addr_i[0]  = A_INSTR;
    bus.m_addr_i[1]  = A_DATA;
    bus.m_we_i       = 2'b10;
    bus.m_be_i[0]    = 4'hF;
    bus.m_be_i[1]    = 4'h3;
    bus.m_wdata_i[0] = 32'h0;
    bus.m_wdata_i[1] = 32'h5555_AAAA;
    bus.s_gnt_i      = 1'b0;
    bus.s_rvalid_i   = 1'b0;
    bus.s_rdata_i    = 32'h0;
    repeat (2) @(negedge clk);

    test_reset();
    test_single_read();
    test_contention();
    test_backpressure();
    test_full_fifo();
    test_hold_drop();
    test_orphan_rvalid();
    test_reset_midflight();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
